// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// state encoding and IR field positions.
package cpu_ctl_pkg;

  localparam int OP_W      = 5;
  localparam int REG_SEL_W = 4;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_NEG = 5'b01001;
  localparam logic [OP_W-1:0] OP_NOT = 5'b01010;

  // The ALU numbers its unary functions one above their opcodes.
  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_SUB = 5'b00100;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00110;
  localparam logic [OP_W-1:0] ALU_NEG = 5'b01010;
  localparam logic [OP_W-1:0] ALU_NOT = 5'b01011;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4U   = 4'd5,
    S_T4B   = 4'd6,
    S_T5B   = 4'd7,
    S_END   = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  function automatic logic [OP_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return '0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic op_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot register select decoder with enable; all outputs low when disabled.
module reg_select_decoder #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: sequences datapath strobes for instruction fetch and
// ALU-class execute, with Moore outputs decoded from the state register.
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic                Mem_Ready,
  input  logic [31:0]         IR,
  output logic                PC_Out,
  output logic                ZLO_Out,
  output logic                MDR_Out,
  output logic                MAR_In,
  output logic                PC_In,
  output logic                MDR_In,
  output logic                IR_In,
  output logic                Y_In,
  output logic                Z_In,
  output logic                IncPC,
  output logic                Read,
  output logic [OPC_W-1:0]    CONTROL,
  output logic [NUM_REGS-1:0] R_In,
  output logic [NUM_REGS-1:0] R_Out,
  output logic                Halted,
  output logic                Fault
);

  state_t state;
  state_t state_next;
  logic   t1_held;

  logic [OP_W-1:0]      op;
  logic [REG_SEL_W-1:0] ra;
  logic [REG_SEL_W-1:0] rb;
  logic [REG_SEL_W-1:0] rc;
  logic [REG_SEL_W-1:0] rout_sel;
  logic                 rin_en;
  logic                 rout_en;
  logic                 unused_ir_bits;

  assign op = IR[IR_OP_HI:IR_OP_LO];
  assign ra = IR[IR_RA_HI:IR_RA_LO];
  assign rb = IR[IR_RB_HI:IR_RB_LO];
  assign rc = IR[IR_RC_HI:IR_RC_LO];
  assign unused_ir_bits = ^IR[IR_RC_LO-1:0];

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state   <= S_IDLE;
      t1_held <= 1'b0;
    end else begin
      state   <= state_next;
      // Remembers that T1 has already lasted a cycle so PC_In fires only once.
      t1_held <= (state == S_T1);
    end
  end

  always_comb begin
    state_next = state;
    PC_Out     = 1'b0;
    ZLO_Out    = 1'b0;
    MDR_Out    = 1'b0;
    MAR_In     = 1'b0;
    PC_In      = 1'b0;
    MDR_In     = 1'b0;
    IR_In      = 1'b0;
    Y_In       = 1'b0;
    Z_In       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    CONTROL    = '0;
    Halted     = 1'b0;
    Fault      = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_sel   = rb;

    case (state)
      S_IDLE: begin
        Halted = 1'b1;
        if (Run) state_next = S_T0;
      end
      S_T0: begin
        PC_Out     = 1'b1;
        MAR_In     = 1'b1;
        IncPC      = 1'b1;
        Z_In       = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        ZLO_Out = 1'b1;
        PC_In   = !t1_held;
        Read    = 1'b1;
        MDR_In  = 1'b1;
        if (Mem_Ready) state_next = S_T2;
      end
      S_T2: begin
        MDR_Out    = 1'b1;
        IR_In      = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        if (!op_legal(op)) begin
          state_next = S_FAULT;
        end else begin
          rout_en = 1'b1;
          if (op_unary(op)) begin
            CONTROL    = alu_code(op);
            Z_In       = 1'b1;
            state_next = S_T4U;
          end else begin
            Y_In       = 1'b1;
            state_next = S_T4B;
          end
        end
      end
      S_T4U: begin
        ZLO_Out    = 1'b1;
        rin_en     = 1'b1;
        state_next = S_END;
      end
      S_T4B: begin
        rout_en    = 1'b1;
        rout_sel   = rc;
        CONTROL    = alu_code(op);
        Z_In       = 1'b1;
        state_next = S_T5B;
      end
      S_T5B: begin
        ZLO_Out    = 1'b1;
        rin_en     = 1'b1;
        state_next = S_END;
      end
      S_END: begin
        state_next = Run ? S_T0 : S_IDLE;
      end
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  reg_select_decoder #(
    .N     (NUM_REGS),
    .SEL_W (REG_SEL_W)
  ) u_rin_decoder (
    .en     (rin_en),
    .sel    (ra),
    .onehot (R_In)
  );

  reg_select_decoder #(
    .N     (NUM_REGS),
    .SEL_W (REG_SEL_W)
  ) u_rout_decoder (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (R_Out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: expected per-cycle strobes are built
// from each instruction's class and checked every cycle by one compare process.
module tb_control_sequencer;

  typedef struct packed {
    logic        pcOut;
    logic        zloOut;
    logic        mdrOut;
    logic        marIn;
    logic        pcIn;
    logic        mdrIn;
    logic        irIn;
    logic        yIn;
    logic        zIn;
    logic        incPc;
    logic        read;
    logic [4:0]  control;
    logic [15:0] rIn;
    logic [15:0] rOut;
    logic        halted;
    logic        fault;
  } exp_t;

  logic        Clock;
  logic        Clear;
  logic        Run;
  logic        Mem_Ready;
  logic [31:0] IR;
  logic        PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In;
  logic        Y_In, Z_In, IncPC, Read, Halted, Fault;
  logic [4:0]  CONTROL;
  logic [15:0] R_In, R_Out;

  exp_t  expCur;
  string expName;
  bit    chkOn;
  int    checkCount;
  int    errorCount;

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Run       (Run),
    .Mem_Ready (Mem_Ready),
    .IR        (IR),
    .PC_Out    (PC_Out),
    .ZLO_Out   (ZLO_Out),
    .MDR_Out   (MDR_Out),
    .MAR_In    (MAR_In),
    .PC_In     (PC_In),
    .MDR_In    (MDR_In),
    .IR_In     (IR_In),
    .Y_In      (Y_In),
    .Z_In      (Z_In),
    .IncPC     (IncPC),
    .Read      (Read),
    .CONTROL   (CONTROL),
    .R_In      (R_In),
    .R_Out     (R_Out),
    .Halted    (Halted),
    .Fault     (Fault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic bit isLegal(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b01010};
  endfunction

  function automatic bit isUnary(input logic [4:0] op);
    return (op == 5'b01001) || (op == 5'b01010);
  endfunction

  function automatic logic [4:0] aluOf(input logic [4:0] op);
    case (op)
      5'b01001: return 5'b01010;
      5'b01010: return 5'b01011;
      default:  return op;
    endcase
  endfunction

  function automatic logic [15:0] onehotOf(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic logic rndBit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic exp_t idleExp();
    exp_t e;
    e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t act;
    int   drivers;
    act = {PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In,
           IncPC, Read, CONTROL, R_In, R_Out, Halted, Fault};
    checkCount++;
    if (act !== expCur) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %h required %h", expName, $time, act, expCur);
    end
    drivers = int'(PC_Out) + int'(ZLO_Out) + int'(MDR_Out) + int'(|R_Out);
    checkCount++;
    if (drivers > 1 || !$onehot0(R_In) || !$onehot0(R_Out)) begin
      errorCount++;
      $display("[TB] FAIL bus_exclusive %s: drivers=%0d R_In=%h R_Out=%h required <=1 and one-hot",
               expName, drivers, R_In, R_Out);
    end
  endtask

  always @(negedge Clock) begin
    if (chkOn) checkOutput();
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act !== req) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input exp_t e, input string name, input logic run,
                               input logic mr, input logic [31:0] ir);
    expCur    = e;
    expName   = name;
    Run       = run;
    Mem_Ready = mr;
    IR        = ir;
    @(posedge Clock);
    #1;
  endtask

  task automatic idleThenGo(input int n);
    for (int i = 0; i < n; i++) applyStimulus(idleExp(), "IDLE", 1'b0, rndBit(), $urandom);
    applyStimulus(idleExp(), "IDLE_go", 1'b1, rndBit(), $urandom);
  endtask

  task automatic clearFault();
    Clear = 1'b0;
    #1;
    expCur  = idleExp();
    expName = "clear_from_fault";
    checkOutput();
    applyStimulus(idleExp(), "IDLE_in_clear", 1'b0, rndBit(), $urandom);
    Clear = 1'b1;
  endtask

  // Walks one instruction from T0, building each cycle's expected strobes.
  task automatic runInstr(input logic [31:0] ir, input int waits, input bit runEnd,
                          input bit dropInT2, input bit resetInT4B, output int cycles);
    exp_t       e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       runMid;
    op = ir[31:27];
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    cycles = 0;

    e = '0; e.pcOut = 1; e.marIn = 1; e.incPc = 1; e.zIn = 1;
    applyStimulus(e, "T0", rndBit(), rndBit(), $urandom); cycles++;

    for (int k = 0; k <= waits; k++) begin
      e = '0; e.zloOut = 1; e.read = 1; e.mdrIn = 1; e.pcIn = (k == 0);
      applyStimulus(e, "T1", rndBit(), (k == waits), $urandom); cycles++;
    end

    runMid = dropInT2 ? 1'b0 : rndBit();
    e = '0; e.mdrOut = 1; e.irIn = 1;
    applyStimulus(e, "T2", runMid, rndBit(), ir); cycles++;

    e = '0;
    if (isLegal(op)) begin
      e.rOut = onehotOf(rb);
      if (isUnary(op)) begin
        e.control = aluOf(op);
        e.zIn = 1;
      end else begin
        e.yIn = 1;
      end
    end
    if (dropInT2) runMid = 1'b0; else runMid = rndBit();
    applyStimulus(e, "T3", runMid, rndBit(), ir); cycles++;

    if (!isLegal(op)) begin
      e = '0; e.fault = 1;
      for (int i = 0; i < 20; i++) applyStimulus(e, "FAULT", rndBit(), rndBit(), ir);
      return;
    end

    if (isUnary(op)) begin
      e = '0; e.zloOut = 1; e.rIn = onehotOf(ra);
      applyStimulus(e, "T4U", dropInT2 ? 1'b0 : rndBit(), rndBit(), ir); cycles++;
    end else begin
      e = '0; e.rOut = onehotOf(rc); e.control = aluOf(op); e.zIn = 1;
      if (resetInT4B) begin
        expCur  = e;
        expName = "T4B";
        #2;
        Clear = 1'b0;
        expCur  = idleExp();
        expName = "async_reset";
        #1;
        checkOutput();
        @(posedge Clock);
        #1;
        Clear = 1'b1;
        return;
      end
      applyStimulus(e, "T4B", rndBit(), rndBit(), ir); cycles++;
      e = '0; e.zloOut = 1; e.rIn = onehotOf(ra);
      applyStimulus(e, "T5B", dropInT2 ? 1'b0 : rndBit(), rndBit(), ir); cycles++;
    end

    applyStimulus('0, "END", runEnd, rndBit(), ir); cycles++;
  endtask

  initial begin
    int         cyc;
    bit         atT0;
    logic [4:0] op;
    logic [31:0] ir;
    bit         runEnd;

    checkCount = 0;
    errorCount = 0;
    chkOn      = 1'b0;
    Clear      = 1'b0;
    Run        = 1'b0;
    Mem_Ready  = 1'b0;
    IR         = '0;
    expCur     = idleExp();
    expName    = "reset";

    @(posedge Clock);
    #1;
    chkOn = 1'b1;
    applyStimulus(idleExp(), "reset", 1'b1, 1'b1, 32'h0);
    applyStimulus(idleExp(), "reset", 1'b1, 1'b1, 32'h0);
    Clear = 1'b1;

    // Directed NEG then ADD, back to back.
    ir = 32'h4A920000;
    checkValue("neg_model_rout", 32'(onehotOf(ir[22:19])), 32'h0004);
    checkValue("neg_model_rin", 32'(onehotOf(ir[26:23])), 32'h0020);
    checkValue("neg_model_control", 32'(aluOf(ir[31:27])), 32'h0A);
    idleThenGo(1);
    runInstr(ir, 0, 1'b1, 1'b0, 1'b0, cyc);
    checkValue("neg_latency", 32'(cyc), 32'd6);

    ir = 32'h18920000;
    checkValue("add_model_rout_rc", 32'(onehotOf(ir[18:15])), 32'h0010);
    checkValue("add_model_rin", 32'(onehotOf(ir[26:23])), 32'h0002);
    runInstr(ir, 0, 1'b0, 1'b0, 1'b0, cyc);
    checkValue("add_latency", 32'(cyc), 32'd7);

    // Memory wait of three cycles.
    idleThenGo(2);
    runInstr(32'h20CA8000, 3, 1'b0, 1'b0, 1'b0, cyc);
    checkValue("wait_latency", 32'(cyc), 32'd10);

    // Illegal opcode faults until Clear.
    idleThenGo(0);
    runInstr(32'hF8000000, 0, 1'b0, 1'b0, 1'b0, cyc);
    clearFault();

    // Asynchronous reset in the middle of T4B, then a clean restart.
    idleThenGo(0);
    runInstr(32'h18920000, 0, 1'b1, 1'b0, 1'b1, cyc);
    idleThenGo(1);
    runInstr(32'h18920000, 0, 1'b0, 1'b0, 1'b0, cyc);

    // Run dropped during T2 of a NEG.
    idleThenGo(0);
    runInstr(32'h4A920000, 0, 1'b0, 1'b1, 1'b0, cyc);
    idleThenGo(5);

    atT0 = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 5'($urandom_range(0, 31));
        while (isLegal(op)) op = 5'($urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 5))
          0: op = 5'b00011;
          1: op = 5'b00100;
          2: op = 5'b00101;
          3: op = 5'b00110;
          4: op = 5'b01001;
          default: op = 5'b01010;
        endcase
      end
      ir = $urandom;
      ir[31:27] = op;
      runEnd = bit'($urandom_range(0, 1));
      if (!atT0) idleThenGo($urandom_range(0, 2));
      runInstr(ir, $urandom_range(0, 3), runEnd, bit'($urandom_range(0, 1)), 1'b0, cyc);
      if (!isLegal(op)) begin
        clearFault();
        atT0 = 1'b0;
      end else begin
        atT0 = runEnd;
      end
    end

    chkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
